// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the PC / instruction-fetch sequencer: state encoding and parameter defaults.
package pc_fetch_ctrl_pkg;

    localparam int          WIDTH_DEF       = 16;
    localparam logic [15:0] RESET_PC_DEF    = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_EXEC   = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

endpackage

// File: rtl/pc_fetch_ctrl_pc_register.sv
// Load-enabled register with asynchronous active-low reset to a parameter value.
module pc_register #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and instruction-fetch sequencer with HALT detection
// and a saturating retired-instruction counter.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_FETCH  | request imem at pc, wait for imem_ready, capture instruction
//  ST_EXEC   | instruction held for decode, wait for commit without stall
//  ST_HALTED | HALT committed; everything frozen until reset
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]       HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] next_pc,
    output logic [WIDTH-1:0] npc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             stall,
    input  logic             commit,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    output logic             halted,
    output logic [WIDTH-1:0] retired_count
);

    state_t           state, state_nxt;
    logic             req_q, valid_q, halted_q;
    logic             req_nxt, valid_nxt, halted_nxt;
    logic             fetch_done, commit_ok, is_halt;
    logic [WIDTH-1:0] pc, ir, cnt;

    // req_q gates the handshake so ready seen before the first request cycle is ignored
    assign fetch_done = (state == ST_FETCH) && req_q && imem_ready;
    assign commit_ok  = (state == ST_EXEC) && commit && !stall;
    assign is_halt    = (ir[WIDTH-1 -: 4] == HALT_OPCODE);

    pc_register #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .rst_n (reset),
        .load  (commit_ok && !is_halt),
        .d     (next_pc),
        .q     (pc)
    );

    pc_register #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir (
        .clk   (clk),
        .rst_n (reset),
        .load  (fetch_done),
        .d     (imem_rdata),
        .q     (ir)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  if (fetch_done) state_nxt = ST_EXEC;
            ST_EXEC:   if (commit_ok)  state_nxt = is_halt ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_FETCH;
        endcase
        req_nxt    = (state_nxt == ST_FETCH);
        valid_nxt  = (state_nxt == ST_EXEC);
        halted_nxt = (state_nxt == ST_HALTED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_FETCH;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_q    <= req_nxt;
            valid_q  <= valid_nxt;
            halted_q <= halted_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (commit_ok && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign npc           = pc;
    assign imem_addr     = pc;
    assign imem_req      = req_q;
    assign instr         = ir;
    assign instr_valid   = valid_q;
    assign halted        = halted_q;
    assign retired_count = cnt;

endmodule
